// File: rtl/mem_stage_dm.sv
`default_nettype none
// ============================================================================
//  Module   : mem_stage_dm
//  Purpose  : MEM-stage data memory for the 5-stage MIPS pipeline. Handles
//             byte/half/word stores with lane merging and sign- or
//             zero-extended loads, flags misaligned / out-of-range /
//             reserved-size accesses, clears the array after reset (busy is
//             held high meanwhile) and registers a one-cycle write-event
//             record for tracing.
//  Ports    : clk, reset         - clock, synchronous active-high reset
//             pc                 - PC of the instruction in MEM (trace only)
//             mem_write/mem_read - store / load request
//             mem_size           - 0 word, 1 half, 2 byte, 3 reserved
//             load_unsigned      - zero-extend sub-word loads when 1
//             addr, wdata        - byte address, store data
//             rdata              - extended load result (combinational)
//             byteen             - lanes written this cycle (combinational)
//             addr_err           - bad access flag (combinational)
//             busy               - post-reset clear in progress
//             wr_ev*             - registered write-event record
//  Revision : 1.0 - initial release
// ============================================================================
module mem_stage_dm #(
    parameter int          DEPTH_WORDS = 3072,
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic        mem_write,
    input  logic        mem_read,
    input  logic [1:0]  mem_size,
    input  logic        load_unsigned,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [3:0]  byteen,
    output logic        addr_err,
    output logic        busy,
    output logic        wr_ev,
    output logic [31:0] wr_ev_pc,
    output logic [31:0] wr_ev_addr,
    output logic [31:0] wr_ev_data
);

    localparam int                 c_IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX   = c_IDX_W'(DEPTH_WORDS - 1);
    localparam logic [32:0]        c_BYTE_LIMIT = 33'(4 * DEPTH_WORDS);

    localparam logic [1:0] c_SZ_WORD = 2'd0;
    localparam logic [1:0] c_SZ_HALF = 2'd1;
    localparam logic [1:0] c_SZ_BYTE = 2'd2;
    localparam logic [1:0] c_SZ_RSVD = 2'd3;

    localparam logic [0:0] c_ST_INIT = 1'b0;
    localparam logic [0:0] c_ST_RUN  = 1'b1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    logic [c_IDX_W-1:0] r_clear_idx;
    logic [c_IDX_W-1:0] w_clear_idx_nxt;

    logic [31:0]        r_mem [0:DEPTH_WORDS-1];

    logic               r_wr_ev;
    logic [31:0]        r_wr_ev_pc;
    logic [31:0]        r_wr_ev_addr;
    logic [31:0]        r_wr_ev_data;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [31:0]        w_off;
    logic               w_out_of_range;
    logic               w_misaligned;
    logic               w_addr_err;
    logic [c_IDX_W-1:0] w_idx;
    logic [31:0]        w_old_word;

    assign w_off          = addr - ADDR_BASE;
    assign w_out_of_range = ({1'b0, w_off} >= c_BYTE_LIMIT);
    assign w_misaligned   = ((mem_size == c_SZ_WORD) && (w_off[1:0] != 2'b00)) ||
                            ((mem_size == c_SZ_HALF) && w_off[0]);
    assign w_addr_err     = (mem_read | mem_write) &
                            (w_out_of_range | w_misaligned | (mem_size == c_SZ_RSVD));

    // Out-of-range accesses are forced onto word 0 so the array is never
    // indexed past its end; their results are discarded by addr_err anyway.
    assign w_idx      = w_out_of_range ? '0 : w_off[c_IDX_W+1:2];
    assign w_old_word = r_mem[w_idx];

    // ------------------------------------------------------------------
    // State machine: INIT clears one word per cycle, RUN serves requests
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_ST_INIT;
            r_clear_idx <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_clear_idx <= w_clear_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_clear_idx_nxt = r_clear_idx;
        case (r_state)
            c_ST_INIT: begin
                if (r_clear_idx == c_LAST_IDX) begin
                    w_state_nxt     = c_ST_RUN;
                    w_clear_idx_nxt = '0;
                end else begin
                    w_clear_idx_nxt = r_clear_idx + c_IDX_W'(1);
                end
            end
            default: begin
                w_state_nxt = c_ST_RUN;
            end
        endcase
    end

    logic w_busy;
    logic w_clearing;
    logic w_commit;

    assign w_busy     = (r_state == c_ST_INIT);
    assign w_clearing = w_busy & ~reset;
    // A store arriving on a reset edge is dropped along with everything else.
    assign w_commit   = (r_state == c_ST_RUN) & mem_write & ~w_addr_err & ~reset;

    // ------------------------------------------------------------------
    // Store path: lane select, data replication, merge with old word
    // ------------------------------------------------------------------
    logic [3:0]  w_lanes;
    logic [31:0] w_store_data;
    logic [31:0] w_merged;

    always_comb begin
        w_lanes      = 4'b0000;
        w_store_data = wdata;
        case (mem_size)
            c_SZ_WORD: begin
                w_lanes      = 4'b1111;
                w_store_data = wdata;
            end
            c_SZ_HALF: begin
                w_lanes      = w_off[1] ? 4'b1100 : 4'b0011;
                w_store_data = {2{wdata[15:0]}};
            end
            c_SZ_BYTE: begin
                w_lanes      = 4'b0001 << w_off[1:0];
                w_store_data = {4{wdata[7:0]}};
            end
            default: begin
                w_lanes      = 4'b0000;
                w_store_data = wdata;
            end
        endcase
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign w_merged[8*gi +: 8] = w_lanes[gi] ? w_store_data[8*gi +: 8]
                                                 : w_old_word[8*gi +: 8];
    end

    // Single write port shared by the clear sweep and committed stores;
    // the two are mutually exclusive by state.
    logic               w_mem_we;
    logic [c_IDX_W-1:0] w_mem_widx;
    logic [31:0]        w_mem_wdata;

    assign w_mem_we    = w_clearing | w_commit;
    assign w_mem_widx  = w_clearing ? r_clear_idx : w_idx;
    assign w_mem_wdata = w_clearing ? 32'h0000_0000 : w_merged;

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_widx] <= w_mem_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Load path: reads pre-edge contents, no forwarding from a same-cycle
    // store
    // ------------------------------------------------------------------
    logic [7:0]  w_ld_byte;
    logic [15:0] w_ld_half;
    logic [31:0] w_rdata;

    assign w_ld_byte = w_old_word[8*w_off[1:0] +: 8];
    assign w_ld_half = w_off[1] ? w_old_word[31:16] : w_old_word[15:0];

    always_comb begin
        w_rdata = 32'h0000_0000;
        if (mem_read && !w_addr_err && !w_busy) begin
            case (mem_size)
                c_SZ_WORD: w_rdata = w_old_word;
                c_SZ_HALF: w_rdata = {{16{~load_unsigned & w_ld_half[15]}}, w_ld_half};
                c_SZ_BYTE: w_rdata = {{24{~load_unsigned & w_ld_byte[7]}}, w_ld_byte};
                default:   w_rdata = 32'h0000_0000;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Write-event record
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ev      <= 1'b0;
            r_wr_ev_pc   <= 32'h0000_0000;
            r_wr_ev_addr <= 32'h0000_0000;
            r_wr_ev_data <= 32'h0000_0000;
        end else begin
            r_wr_ev <= w_commit;
            if (w_commit) begin
                r_wr_ev_pc   <= pc;
                r_wr_ev_addr <= {w_off[31:2], 2'b00} + ADDR_BASE;
                r_wr_ev_data <= w_merged;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign rdata      = w_rdata;
    assign byteen     = w_commit ? w_lanes : 4'b0000;
    assign addr_err   = w_addr_err;
    assign busy       = w_busy;
    assign wr_ev      = r_wr_ev;
    assign wr_ev_pc   = r_wr_ev_pc;
    assign wr_ev_addr = r_wr_ev_addr;
    assign wr_ev_data = r_wr_ev_data;

endmodule
`default_nettype wire
